// File: rtl/alu_arbiter_if.sv
// Requester/response handshake bundle for alu_arbiter.
// The resp_err signal exists only when ALU_ARB_OPCHECK_EN is defined.
interface alu_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              resp0_valid;
  logic              resp0_ready;
  logic              resp1_valid;
  logic              resp1_ready;
  logic [DATA_W-1:0] resp_y;
  logic              resp_carry;
`ifdef ALU_ARB_OPCHECK_EN
  logic              resp_err;
`endif

  // Requesters side.
  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp0_ready, resp1_ready,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
    input  resp_y, resp_carry
`ifdef ALU_ARB_OPCHECK_EN
    , input resp_err
`endif
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp0_ready, resp1_ready,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
    output resp_y, resp_carry
`ifdef ALU_ARB_OPCHECK_EN
    , output resp_err
`endif
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Optional opcode check (resp_err) is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_carry,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   gid;
  logic   grant;
  logic   req_fire;
  logic   resp_fire;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_fire)  state_nxt = EXEC;
      EXEC:                   state_nxt = RESP;
      RESP:    if (resp_fire) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // Grant, handshake and status outputs; nothing is offered while rst is high.
  always_comb begin
    grant           = 1'b0;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    req_fire        = 1'b0;
    resp_fire       = 1'b0;
    busy            = (state != IDLE);
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
    if (!rst && state == IDLE) begin
      bus.req0_ready = bus.req0_valid && (grant == 1'b0);
      bus.req1_ready = bus.req1_valid && (grant == 1'b1);
      req_fire       = bus.req0_ready || bus.req1_ready;
    end
    if (!rst && state == RESP) begin
      bus.resp0_valid = (gid == 1'b0);
      bus.resp1_valid = (gid == 1'b1);
      resp_fire       = gid ? bus.resp1_ready : bus.resp0_ready;
    end
  end

  // Operand capture, result buffer and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a          <= '0;
      alu_b          <= '0;
      alu_op         <= '0;
      bus.resp_y     <= '0;
      bus.resp_carry <= 1'b0;
      gid            <= 1'b0;
      last_grant     <= 1'b1;
    end else begin
      if (req_fire) begin
        gid    <= grant;
        alu_a  <= grant ? bus.req1_a  : bus.req0_a;
        alu_b  <= grant ? bus.req1_b  : bus.req0_b;
        alu_op <= grant ? bus.req1_op : bus.req0_op;
      end
      if (state == EXEC) begin
        bus.resp_y     <= alu_y;
        bus.resp_carry <= alu_carry;
      end
      if (resp_fire) last_grant <= gid;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  // Flags opcodes beyond the ALU's supported range alongside the result.
  always_ff @(posedge clk) begin
    if (rst)                 bus.resp_err <= 1'b0;
    else if (state == EXEC)  bus.resp_err <= (alu_op > OP_W'(4'b1001));
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_op;
  logic       alu_carry;
  logic       busy;
  int         checks   = 0;
  int         failures = 0;

  alu_arbiter_if #(.DATA_W(8), .OP_W(4)) bus ();

  alu_arbiter #(.DATA_W(8), .OP_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_carry(alu_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 sub (borrow in carry), 7 shift right by b, 8 shift left by 1.
  always_comb begin
    logic [8:0] t;
    t = 9'h000;
    case (alu_op)
      4'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
      4'd1: t = {1'b0, alu_a} - {1'b0, alu_b};
      4'd2: t = {1'b0, alu_a & alu_b};
      4'd3: t = {1'b0, alu_a | alu_b};
      4'd7: t = {1'b0, alu_a >> alu_b[2:0]};
      4'd8: t = {alu_a, 1'b0};
      default: t = 9'h000;
    endcase
    alu_y     = t[7:0];
    alu_carry = t[8];
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_op = 0;
    bus.resp0_ready = 0; bus.resp1_ready = 0;
    do_reset();
    #1;
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_op", 8'(alu_op), 8'h0);
    chk("rst_resp_y", bus.resp_y, 8'h00);
    chk("rst_resp_valid", 8'({bus.resp0_valid, bus.resp1_valid}), 8'h0);
    chk("rst_ready", 8'({bus.req0_ready, bus.req1_ready}), 8'h0);

    // Single add with carry-out from port 0.
    bus.req0_valid = 1; bus.req0_a = 8'hF0; bus.req0_b = 8'h20; bus.req0_op = 4'd0;
    bus.resp0_ready = 1;
    #1;
    chk("add_req0_ready", 8'(bus.req0_ready), 8'h1);
    chk("add_busy_idle", 8'(busy), 8'h0);
    step();
    bus.req0_valid = 0;
    #1;
    chk("add_busy_exec", 8'(busy), 8'h1);
    chk("add_alu_a", alu_a, 8'hF0);
    chk("add_alu_b", alu_b, 8'h20);
    chk("add_resp_early", 8'(bus.resp0_valid), 8'h0);
    step();
    chk("add_resp0_valid", 8'(bus.resp0_valid), 8'h1);
    chk("add_resp1_valid", 8'(bus.resp1_valid), 8'h0);
    chk("add_resp_y", bus.resp_y, 8'h10);
    chk("add_carry", 8'(bus.resp_carry), 8'h1);
    step();
    chk("add_busy_done", 8'(busy), 8'h0);
    chk("add_y_hold", bus.resp_y, 8'h10);

    // Fairness: both requesting continuously from reset.
    do_reset();
    bus.req0_valid = 1; bus.req0_a = 8'd5; bus.req0_b = 8'd3; bus.req0_op = 4'd1;
    bus.req1_valid = 1; bus.req1_a = 8'd5; bus.req1_b = 8'd3; bus.req1_op = 4'd7;
    bus.resp0_ready = 1; bus.resp1_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready0", 8'(bus.req0_ready), (k % 2 == 0) ? 8'h1 : 8'h0);
      chk("rr_ready1", 8'(bus.req1_ready), (k % 2 == 1) ? 8'h1 : 8'h0);
      step();
      chk("rr_ready_busy", 8'({bus.req0_ready, bus.req1_ready}), 8'h0);
      step();
      chk("rr_resp0_valid", 8'(bus.resp0_valid), (k % 2 == 0) ? 8'h1 : 8'h0);
      chk("rr_resp1_valid", 8'(bus.resp1_valid), (k % 2 == 1) ? 8'h1 : 8'h0);
      chk("rr_resp_y", bus.resp_y, (k % 2 == 0) ? 8'h02 : 8'h00);
      step();
    end
    bus.req0_valid = 0; bus.req1_valid = 0;

    // Backpressure on port 1, with a borrowing subtract.
    bus.req1_valid = 1; bus.req1_a = 8'h03; bus.req1_b = 8'h05; bus.req1_op = 4'd1;
    bus.resp1_ready = 0;
    #1;
    chk("bp_req1_ready", 8'(bus.req1_ready), 8'h1);
    step();
    bus.req1_valid = 0;
    bus.req0_valid = 1; bus.req0_a = 8'h01; bus.req0_b = 8'h01; bus.req0_op = 4'd0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp1_valid", 8'(bus.resp1_valid), 8'h1);
      chk("bp_resp0_valid", 8'(bus.resp0_valid), 8'h0);
      chk("bp_resp_y", bus.resp_y, 8'hFE);
      chk("bp_carry", 8'(bus.resp_carry), 8'h1);
      chk("bp_req0_ready", 8'(bus.req0_ready), 8'h0);
      step();
    end
    bus.resp1_ready = 1;
    step();
    chk("bp_idle", 8'(busy), 8'h0);
    chk("bp_req0_now", 8'(bus.req0_ready), 8'h1);
    step();
    bus.req0_valid = 0;
    step();
    chk("bp_p0_valid", 8'(bus.resp0_valid), 8'h1);
    chk("bp_p0_y", bus.resp_y, 8'h02);
    step();

    // Reset while an operation is executing.
    bus.req0_valid = 1; bus.req0_a = 8'h03; bus.req0_b = 8'h04; bus.req0_op = 4'd0;
    step();
    bus.req0_valid = 0;
    chk("mr_in_exec", 8'(busy), 8'h1);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("mr_busy", 8'(busy), 8'h0);
    chk("mr_alu_a", alu_a, 8'h00);
    chk("mr_resp_y", bus.resp_y, 8'h00);
    chk("mr_valids", 8'({bus.resp0_valid, bus.resp1_valid}), 8'h0);
    step();
    chk("mr_no_resp", 8'({bus.resp0_valid, bus.resp1_valid}), 8'h0);
    bus.req0_valid = 1;
    bus.req1_valid = 1; bus.req1_op = 4'd0;
    #1;
    chk("mr_grant0", 8'(bus.req0_ready), 8'h1);
    chk("mr_grant1", 8'(bus.req1_ready), 8'h0);
    step();
    bus.req0_valid = 0; bus.req1_valid = 0;
    step();
    chk("mr_resp_y2", bus.resp_y, 8'h07);
    step();

    // Port 1 valid withdrawn while busy.
    bus.req0_valid = 1; bus.req0_a = 8'h09; bus.req0_b = 8'h01; bus.req0_op = 4'd1;
    step();
    bus.req0_valid = 0;
    bus.req1_valid = 1;
    #1;
    chk("wd_ready_exec", 8'(bus.req1_ready), 8'h0);
    step();
    bus.req1_valid = 0;
    chk("wd_resp0", 8'(bus.resp0_valid), 8'h1);
    chk("wd_y", bus.resp_y, 8'h08);
    step();
    chk("wd_idle", 8'(busy), 8'h0);
    step();
    chk("wd_no_grant", 8'(busy), 8'h0);
    chk("wd_no_resp1", 8'(bus.resp1_valid), 8'h0);

`ifdef ALU_ARB_OPCHECK_EN
    bus.req0_valid = 1; bus.req0_a = 8'h55; bus.req0_b = 8'h0F; bus.req0_op = 4'b1100;
    step();
    bus.req0_valid = 0;
    step();
    chk("oc_bad_y", bus.resp_y, 8'h00);
    chk("oc_bad_err", 8'(bus.resp_err), 8'h1);
    step();
    bus.req0_valid = 1; bus.req0_a = 8'h81; bus.req0_b = 8'h00; bus.req0_op = 4'b1000;
    step();
    bus.req0_valid = 0;
    step();
    chk("oc_ok_y", bus.resp_y, 8'h02);
    chk("oc_ok_err", 8'(bus.resp_err), 8'h0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU between two requesters (port 0, port 1) using valid/ready handshakes.
- Round-robin arbitration; one operation in flight at a time.
- Operands are registered into the ALU inputs and the ALU result is registered into a response buffer held until the owning port accepts it.
- Sits between the CPU control path and a second ALU client (e.g. address/branch unit) and the shared ALU instance.

Parameters:
- DATA_W, 8: operand and result width; must match the ALU.
- OP_W, 4: opcode width; must match the ALU.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- req0_valid  input  1  port 0 request valid
- req0_ready  output  1  port 0 request accepted this cycle
- req0_a  input  DATA_W  port 0 operand a
- req0_b  input  DATA_W  port 0 operand b
- req0_op  input  OP_W  port 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: as port 0, for port 1
- resp0_valid  output  1  result available for port 0
- resp0_ready  input  1  port 0 consumes result
- resp1_valid  output  1  result available for port 1
- resp1_ready  input  1  port 1 consumes result
- resp_y  output  DATA_W  result, shared by both ports
- resp_carry  output  1  carry/borrow, shared by both ports
- alu_a  output  DATA_W  to ALU a
- alu_b  output  DATA_W  to ALU b
- alu_op  output  OP_W  to ALU op
- alu_y  input  DATA_W  from ALU y
- alu_carry  input  1  from ALU carry
- busy  output  1  high whenever state != IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- FSM states: IDLE, EXEC, RESP.
- Reset (any state, including mid-operation):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - alu_a/alu_b/alu_op=0, resp_y=0, resp_carry=0, all valid/ready outputs=0, busy=0.
  - Any in-flight operation is discarded; no response is issued for it.
- IDLE:
  - Grant select: if only one reqN_valid is high, that port wins. If both are high, the port != last_grant wins.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. Combinational; at most one ready high per cycle.
  - On handshake, register reqN_a/b/op into alu_a/alu_b/alu_op, store gid=N, go to EXEC.
  - With no valid: stay in IDLE; ALU input registers hold their previous values.
- EXEC (one cycle):
  - Capture alu_y into resp_y and alu_carry into resp_carry; go to RESP.
- RESP:
  - respN_valid=1 for N==gid only.
  - On resp[gid]_valid && resp[gid]_ready: last_grant=gid, next state=IDLE.
  - The other port's resp_ready is ignored.
  - resp_y/resp_carry stay stable until the next EXEC; they hold the last result while in IDLE.
- Latency: handshake in cycle T gives respN_valid at T+2, provided resp_ready is already high.
- Maximum throughput: one operation per 3 cycles.
- New requests are never accepted in EXEC or RESP. Requests presented then wait, with ready=0.
- A requester may deassert valid before ready; no state change results.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1...
- Arithmetic: no width manipulation in this block. Results, including wrap-around and borrow-in-carry, are passed through from the ALU unchanged.

Optional Feature:
- Macro ALU_ARB_OPCHECK_EN.
- Defined:
  - Adds output port resp_err (1 bit), registered in EXEC.
  - resp_err=1 when the captured opcode is > 4'b1001 (unsupported op); otherwise 0.
  - Reset value 0. resp_err is valid alongside resp0_valid/resp1_valid.
  - The operation still executes; resp_y=0 comes from the ALU.
- Undefined: no resp_err port and no related logic.

Test Plan:
- Reset, then port 0 sends a=8'hF0, b=8'h20, op=0000 -> req0_ready same cycle; resp0_valid 2 cycles later with resp_y=8'h10, resp_carry=1; busy high for 2 cycles plus any resp wait.
- Both ports valid continuously (port 0: a=5, b=3, op=0001; port 1: a=5, b=3, op=0111) -> grant order 0,1,0,1; port 0 gets resp_y=8'h02, port 1 gets resp_y=8'h00; the non-owner resp_valid is never high.
- Backpressure: resp1_ready held low for 5 cycles -> resp1_valid and resp_y stable for 5 cycles; req0_ready stays 0 throughout; IDLE is re-entered the cycle after resp1_ready rises.
- Mid-operation reset: assert rst during EXEC -> next cycle all outputs 0, state IDLE, no resp_valid; the next request from port 0 is granted first (last_grant=1).
- Valid withdrawn: req1_valid pulsed while busy, then dropped before IDLE -> no grant to port 1, no response.
- With ALU_ARB_OPCHECK_EN defined: op=4'b1100 -> resp_y=0, resp_err=1. Then op=4'b1000 with a=8'h81 -> resp_y=8'h02, resp_err=0.
